sram_2p_array: RTL and testbench
================================

Name: sram_2p_array

Overview:
- Parametrised two-port (1W/1R) SRAM array with independent write and read bitline ports, modelled at the behavioural and clocked level.
- The write port commits masked data in one cycle.
- The read port runs a precharge/wordline/sense sequence through a small FSM and returns data with a valid strobe.
- Sits between the mixed-signal array macros and the digital controller; used as the golden timing model and as the synthesisable fallback array.

Parameters:
- DATA_W, 8, word width in bits (1..64).
- DEPTH, 16, number of words (2..1024; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- PRECH_CYC, 1, bitline precharge duration in cycles (1..4).
- RDW_MODE, 0, same-address read-during-write result: 0 returns old data, 1 returns new (masked-merged) data.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, sampled each rising edge
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- wr_mask  in  DATA_W  per-bit write enable; 1 = bit written
- wr_err  out  1  one-cycle pulse: previous-edge write addressed >= DEPTH
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  read word address, latched on acceptance
- rd_ready  out  1  read port can accept a request (FSM in IDLE)
- rd_valid  out  1  one-cycle pulse: rd_data/rd_err valid
- rd_data  out  DATA_W  read data, held until the next rd_valid
- rd_err  out  1  qualifies rd_valid: read address was >= DEPTH

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: rd_ready=1, rd_valid=0, rd_data=0, rd_err=0, wr_err=0. FSM=IDLE, precharge counter=0.
- Array contents are NOT reset. They are undefined after power-up and preserved across rst_n assertion.
- Write port:
  - At a rising edge with wr_en=1 and wr_addr<DEPTH: mem[wr_addr] <= (mem & ~wr_mask) | (wr_data & wr_mask).
  - wr_mask=0 is a legal no-op write.
  - wr_en=1 with wr_addr>=DEPTH: no array change; wr_err=1 for the following cycle only.
  - Writes proceed in every read FSM state, independent of rd_ready.
- Read FSM, states IDLE, PRECH, ACCESS, DONE:
  - IDLE: rd_ready=1. When rd_req=1 at an edge, latch rd_addr, load counter=PRECH_CYC-1, go to PRECH. rd_req while not IDLE is ignored; it is not queued.
  - PRECH: rd_ready=0. If counter==0, go to ACCESS; else decrement.
  - ACCESS: one cycle (wordline asserted). At the exit edge, sample the array into rd_data and go to DONE.
  - DONE: rd_valid=1 for exactly this cycle, then IDLE.
- Latency: request accepted at edge N → rd_valid high in the cycle after edge N+PRECH_CYC+1. Back-to-back throughput is one read per PRECH_CYC+3 cycles. rd_ready returns high in the cycle rd_valid is low again.
- Read data at the ACCESS exit edge:
  - Latched address >= DEPTH: rd_data=0, rd_err=1.
  - Otherwise rd_err=0, rd_data=mem[addr], including all writes committed at earlier edges.
  - Same-edge write to the same address: RDW_MODE=0 returns pre-write contents; RDW_MODE=1 returns the merged post-write word.
  - Same-edge write to a different address has no effect on rd_data.
- rd_data and rd_err are held stable between rd_valid pulses.
- Reset mid-read (any state): FSM to IDLE immediately. The pending read is dropped, no rd_valid is produced, and the array is unchanged.
- Reset during a write edge: the write is not guaranteed to commit.

Test Plan:
- Reset, then write 0xA5 to addr 3 (mask 0xFF), read addr 3 with PRECH_CYC=1 → rd_ready low for 3 cycles; rd_valid pulses once in the 3rd cycle after acceptance; rd_data=0xA5, rd_err=0.
- Masked write: addr 5=0xFF, then wr_data=0x00 with mask 0x0F → read addr 5 returns 0xF0.
- Collision: mem[7]=0x11; issue read of 7 and write 0x22 at the ACCESS exit edge → RDW_MODE=0 gives 0x11, RDW_MODE=1 gives 0x22; a follow-up read gives 0x22 in both modes.
- DEPTH=12: write addr 14 → wr_err pulses 1 cycle and no array word changes; read addr 13 → rd_valid with rd_err=1, rd_data=0.
- PRECH_CYC=4, rd_req held high continuously → rd_valid every 7 cycles; requests during busy cycles are not queued.
- Assert rst_n low during PRECH → rd_ready=1 and rd_valid=0 immediately, no stale pulse after release; previously written data is still readable.

Source files
------------

// File: rtl/sram_2p_array.sv
// Two-port (1W/1R) SRAM array: single-cycle masked write port and a
// precharge/wordline/sense read port sequenced by a small FSM.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   wr_en/wr_addr     write strobe and word address
//   wr_data/wr_mask   write data and per-bit write enable (1 = written)
//   wr_err            1-cycle pulse after a write to an address >= DEPTH
//   rd_req/rd_addr    read request; address latched on acceptance
//   rd_ready          read port idle and able to accept a request
//   rd_valid          1-cycle pulse qualifying rd_data/rd_err
//   rd_data/rd_err    read word (held until next rd_valid), bad-address flag
module sram_2p_array #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int PRECH_CYC = 1,
    parameter int RDW_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    output logic              wr_err,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);

    typedef enum logic [1:0] {
        IDLE,
        PRECH,
        ACCESS,
        DONE
    } state_t;

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      CNT_LOAD = 2'(PRECH_CYC - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;

    logic              wr_in;
    logic              wr_ok;
    logic              rd_ok;
    logic              hit;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_next;

    assign wr_in = {1'b0, wr_addr} < DEPTH_X;
    assign wr_ok = wr_en && wr_in;
    assign rd_ok = {1'b0, addr_q} < DEPTH_X;
    assign hit   = wr_ok && (wr_addr == addr_q);

    always_comb begin
        wr_old = '0;
        if (wr_ok) begin
            wr_old = mem[wr_addr];
        end
        wr_word = (wr_old & ~wr_mask) | (wr_data & wr_mask);
    end

    // Out-of-range reads sense as all zeros.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[addr_q];
        end
        rd_next = rd_word;
        if ((RDW_MODE != 0) && hit) begin
            rd_next = wr_word;
        end
    end

    // Array contents survive reset, so the storage has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            rd_ready <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_err   <= wr_en && !wr_in;
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_req) begin
                        addr_q   <= rd_addr;
                        cnt      <= CNT_LOAD;
                        state    <= PRECH;
                        rd_ready <= 1'b0;
                    end
                end
                PRECH: begin
                    if (cnt == 2'd0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACCESS: begin
                    rd_data  <= rd_next;
                    rd_err   <= !rd_ok;
                    rd_valid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state    <= IDLE;
                    rd_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_2p_array.sv
// Directed bench for sram_2p_array: two instances with different
// depth / precharge / read-during-write settings.
module tb_sram_2p_array;

    logic       clk;
    logic       rst_n;
    logic       wr_en    [2];
    logic [3:0] wr_addr  [2];
    logic [7:0] wr_data  [2];
    logic [7:0] wr_mask  [2];
    logic       wr_err   [2];
    logic       rd_req   [2];
    logic [3:0] rd_addr  [2];
    logic       rd_ready [2];
    logic       rd_valid [2];
    logic [7:0] rd_data  [2];
    logic       rd_err   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance 0: DEPTH=12, PRECH_CYC=1, old data on collision.
    sram_2p_array #(
        .DATA_W(8), .DEPTH(12), .PRECH_CYC(1), .RDW_MODE(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .wr_mask(wr_mask[0]),
        .wr_err(wr_err[0]),
        .rd_req(rd_req[0]), .rd_addr(rd_addr[0]),
        .rd_ready(rd_ready[0]), .rd_valid(rd_valid[0]),
        .rd_data(rd_data[0]), .rd_err(rd_err[0])
    );

    // Instance 1: DEPTH=16, PRECH_CYC=4, merged new data on collision.
    sram_2p_array #(
        .DATA_W(8), .DEPTH(16), .PRECH_CYC(4), .RDW_MODE(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .wr_mask(wr_mask[1]),
        .wr_err(wr_err[1]),
        .rd_req(rd_req[1]), .rd_addr(rd_addr[1]),
        .rd_ready(rd_ready[1]), .rd_valid(rd_valid[1]),
        .rd_data(rd_data[1]), .rd_err(rd_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        int         kind;   // 0 write, 1 read, 2 read + write at ACCESS exit
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
        logic [3:0] waddr;
        logic [7:0] exp;
        logic       err;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int inst, int kind, logic [3:0] addr,
                                logic [7:0] data, logic [7:0] mask,
                                logic [3:0] waddr, logic [7:0] exp,
                                logic err, string nm);
        vec_t v;
        v.inst = inst; v.kind = kind; v.addr = addr;
        v.data = data; v.mask = mask; v.waddr = waddr;
        v.exp = exp; v.err = err; v.nm = nm;
        return v;
    endfunction

    function automatic int pc(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_wr(int i, logic [3:0] a, logic [7:0] d,
                         logic [7:0] m, logic ee, string nm);
        wr_en[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d; wr_mask[i] = m;
        @(negedge clk);
        wr_en[i] = 1'b0;
        chk({nm, "/wr_err"}, 64'(wr_err[i]), 64'(ee));
        @(negedge clk);
        chk({nm, "/wr_err_end"}, 64'(wr_err[i]), 64'(0));
    endtask

    // Accept a read, optionally write at the ACCESS exit edge, and
    // check ready/valid timing plus returned data.
    task automatic do_rd(int i, logic [3:0] a, logic [7:0] ed, logic ee,
                         bit cw, logic [3:0] ca, logic [7:0] cd,
                         logic [7:0] cm, string nm);
        int p;
        int vk;
        int nv;
        int nrl;
        logic [7:0] vd;
        logic ve;
        p = pc(i); vk = 0; nv = 0; nrl = 0; vd = '0; ve = 1'b0;
        chk({nm, "/ready_pre"}, 64'(rd_ready[i]), 64'(1));
        rd_req[i] = 1'b1; rd_addr[i] = a;
        @(negedge clk);
        rd_req[i] = 1'b0;
        for (int k = 1; k <= p + 3; k++) begin
            if (!rd_ready[i]) nrl++;
            if (rd_valid[i]) begin
                nv++;
                vk = k;
                vd = rd_data[i];
                ve = rd_err[i];
            end
            if (cw && k == p + 1) begin
                wr_en[i] = 1'b1; wr_addr[i] = ca;
                wr_data[i] = cd; wr_mask[i] = cm;
            end
            if (k == p + 2) wr_en[i] = 1'b0;
            if (k < p + 3) @(negedge clk);
        end
        chk({nm, "/valid_cycle"}, 64'(vk), 64'(p + 2));
        chk({nm, "/valid_count"}, 64'(nv), 64'(1));
        chk({nm, "/busy_cycles"}, 64'(nrl), 64'(p + 2));
        chk({nm, "/data"}, 64'(vd), 64'(ed));
        chk({nm, "/err"}, 64'(ve), 64'(ee));
        chk({nm, "/data_held"}, 64'(rd_data[i]), 64'(ed));
    endtask

    initial begin
        int np;
        int nv;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
            wr_mask[i] = '0; rd_req[i] = 1'b0; rd_addr[i] = '0;
        end

        tbl.push_back(mk(0, 0, 3,  8'hA5, 8'hFF, 0, 0, 0, "w3"));
        tbl.push_back(mk(0, 1, 3,  0, 0, 0, 8'hA5, 0, "r3"));
        tbl.push_back(mk(0, 0, 5,  8'hFF, 8'hFF, 0, 0, 0, "w5"));
        tbl.push_back(mk(0, 0, 5,  8'h00, 8'h0F, 0, 0, 0, "w5m"));
        tbl.push_back(mk(0, 1, 5,  0, 0, 0, 8'hF0, 0, "r5m"));
        tbl.push_back(mk(0, 0, 11, 8'h3C, 8'hFF, 0, 0, 0, "w11"));
        tbl.push_back(mk(0, 1, 11, 0, 0, 0, 8'h3C, 0, "r11"));
        tbl.push_back(mk(0, 0, 11, 8'hFF, 8'h00, 0, 0, 0, "w11nop"));
        tbl.push_back(mk(0, 1, 11, 0, 0, 0, 8'h3C, 0, "r11nop"));
        tbl.push_back(mk(0, 0, 2,  8'h00, 8'hFF, 0, 0, 0, "w2"));
        tbl.push_back(mk(0, 0, 6,  8'h00, 8'hFF, 0, 0, 0, "w6"));
        tbl.push_back(mk(0, 0, 14, 8'h55, 8'hFF, 0, 0, 1, "w14oob"));
        tbl.push_back(mk(0, 1, 2,  0, 0, 0, 8'h00, 0, "r2post"));
        tbl.push_back(mk(0, 1, 6,  0, 0, 0, 8'h00, 0, "r6post"));
        tbl.push_back(mk(0, 1, 3,  0, 0, 0, 8'hA5, 0, "r3post"));
        tbl.push_back(mk(0, 1, 13, 0, 0, 0, 8'h00, 1, "r13oob"));
        tbl.push_back(mk(0, 1, 12, 0, 0, 0, 8'h00, 1, "r12oob"));
        tbl.push_back(mk(0, 0, 7,  8'h11, 8'hFF, 0, 0, 0, "w7"));
        tbl.push_back(mk(0, 2, 7,  8'h22, 8'hFF, 7, 8'h11, 0, "rdw0"));
        tbl.push_back(mk(0, 1, 7,  0, 0, 0, 8'h22, 0, "rdw0_after"));
        tbl.push_back(mk(0, 2, 3,  8'h99, 8'hFF, 4, 8'hA5, 0, "rdw0_diff"));
        tbl.push_back(mk(1, 0, 15, 8'h81, 8'hFF, 0, 0, 0, "b_w15"));
        tbl.push_back(mk(1, 1, 15, 0, 0, 0, 8'h81, 0, "b_r15"));
        tbl.push_back(mk(1, 0, 2,  8'hC3, 8'hFF, 0, 0, 0, "b_w2"));
        tbl.push_back(mk(1, 0, 2,  8'h3C, 8'h0F, 0, 0, 0, "b_w2m"));
        tbl.push_back(mk(1, 1, 2,  0, 0, 0, 8'hCC, 0, "b_r2"));
        tbl.push_back(mk(1, 0, 7,  8'h11, 8'hFF, 0, 0, 0, "b_w7"));
        tbl.push_back(mk(1, 2, 7,  8'h22, 8'hFF, 7, 8'h22, 0, "rdw1"));
        tbl.push_back(mk(1, 1, 7,  0, 0, 0, 8'h22, 0, "rdw1_after"));
        tbl.push_back(mk(1, 2, 7,  8'h0F, 8'hF0, 7, 8'h02, 0, "rdw1_merge"));
        tbl.push_back(mk(1, 1, 7,  0, 0, 0, 8'h02, 0, "rdw1_merge_after"));
        tbl.push_back(mk(1, 2, 15, 8'h00, 8'hFF, 3, 8'h81, 0, "rdw1_diff"));

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d/rd_ready", i), 64'(rd_ready[i]), 64'(1));
            chk($sformatf("rst%0d/rd_valid", i), 64'(rd_valid[i]), 64'(0));
            chk($sformatf("rst%0d/rd_data", i), 64'(rd_data[i]), 64'(0));
            chk($sformatf("rst%0d/rd_err", i), 64'(rd_err[i]), 64'(0));
            chk($sformatf("rst%0d/wr_err", i), 64'(wr_err[i]), 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[n]) begin
            if (tbl[n].kind == 0)
                do_wr(tbl[n].inst, tbl[n].addr, tbl[n].data, tbl[n].mask,
                      tbl[n].err, tbl[n].nm);
            else
                do_rd(tbl[n].inst, tbl[n].addr, tbl[n].exp, tbl[n].err,
                      tbl[n].kind == 2, tbl[n].waddr, tbl[n].data,
                      tbl[n].mask, tbl[n].nm);
        end

        // Held request on the PRECH_CYC=4 instance: one read per 7 cycles.
        np = 0;
        rd_req[1] = 1'b1; rd_addr[1] = 4'd15;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (rd_valid[1]) begin
                chk($sformatf("held/pulse%0d_cycle", np), 64'(k),
                    64'(6 + 7 * np));
                chk($sformatf("held/pulse%0d_data", np), 64'(rd_data[1]),
                    64'(8'h81));
                np++;
            end
        end
        rd_req[1] = 1'b0;
        chk("held/pulses", 64'(np), 64'(4));
        repeat (8) @(negedge clk);

        // Reset while instance 1 is in PRECH.
        rd_req[1] = 1'b1; rd_addr[1] = 4'd15;
        @(negedge clk);
        rd_req[1] = 1'b0;
        @(negedge clk);
        chk("mid_rst/busy_before", 64'(rd_ready[1]), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst/rd_ready", 64'(rd_ready[1]), 64'(1));
        chk("mid_rst/rd_valid", 64'(rd_valid[1]), 64'(0));
        chk("mid_rst/rd_data", 64'(rd_data[1]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rd_valid[1]) nv++;
        end
        chk("mid_rst/no_stale_valid", 64'(nv), 64'(0));
        do_rd(1, 15, 8'h81, 0, 0, 0, 0, 0, "post_rst_b");
        do_rd(0, 3, 8'hA5, 0, 0, 0, 0, 0, "post_rst_a");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
